ready_seq_multi: RTL and testbench

//   Parametrised reset-release ready sequencer. After reset, or a restart request,

---
 rtl/ready_seq_multi.sv | 80 ++++++++
 tb/tb_ready_seq_multi.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ready_seq_multi.sv
// Reset-release ready sequencer: raises NCH ready flags in order, DLY cycles apart,
// with hold (freeze) and restart (drop everything and resequence from channel 0).
module ready_seq_multi #(
  parameter int NCH = 4,
  parameter int DLY = 2,
  localparam int CW = $clog2(DLY + 1),
  localparam int SW = $clog2(NCH + 1)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           restart_i,
  input  logic           hold_i,
  output logic [NCH-1:0] ready_o,
  output logic           all_ready_o,
  output logic           busy_o,
  output logic [SW-1:0]  stage_o
);

  typedef enum logic {SEQ = 1'b0, DONE = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Handshake-free block: the only contract is the ready_o thermometer, which only
  // grows between a reset/restart and the next one; consumers may sample it any cycle.
  always_ff @(posedge clk) begin
    if (!rstn || restart_i) begin
      ready_o     <= '0;
      all_ready_o <= 1'b0;
      stage_o     <= '0;
      cnt         <= '0;
      state       <= SEQ;
    end else begin
      case (state)
        SEQ: begin
          if (!hold_i) begin
            if (cnt == CW'(DLY - 1)) begin
              cnt <= '0;
              for (int k = 0; k < NCH; k++) begin
                if (stage_o == SW'(k)) ready_o[k] <= 1'b1;
              end
              stage_o <= stage_o + SW'(1);
              if (stage_o == SW'(NCH - 1)) begin
                all_ready_o <= 1'b1;
                state       <= DONE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          // Sequence complete; everything holds until reset or restart.
        end
      endcase
    end
  end

  // busy_o doubles as the visible FSM state (SEQ=1, DONE=0).
  assign busy_o = (state == SEQ);

`ifndef SYNTHESIS
  // Formal environments are expected to start with rstn low.
  a_thermo: assert property (@(posedge clk) disable iff (!rstn)
    (ready_o & (ready_o + NCH'(1))) == '0);
  a_popcount: assert property (@(posedge clk) disable iff (!rstn)
    $countones(ready_o) == int'(stage_o));
  a_all: assert property (@(posedge clk) disable iff (!rstn)
    all_ready_o == &ready_o);
  a_busy: assert property (@(posedge clk) disable iff (!rstn)
    busy_o == !all_ready_o);
  a_cnt: assert property (@(posedge clk) disable iff (!rstn)
    cnt < CW'(DLY));
  a_no_fall: assert property (@(posedge clk)
    (rstn && !restart_i) |=> ((ready_o & $past(ready_o)) == $past(ready_o)));
  a_reset_clear: assert property (@(posedge clk)
    !rstn |=> ready_o == '0);
`endif

endmodule

// File: tb/tb_ready_seq_multi.sv
// Bench for ready_seq_multi: directed table, multi-cycle corner sequences and a
// randomized run, all checked against a progress-count reference model.
module tb_ready_seq_multi;

  localparam int W = 13;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       restart_i = 1'b0;
  logic       hold_i = 1'b0;
  logic [3:0] ready4;
  logic       all4, busy4;
  logic [2:0] stage4;
  logic [0:0] ready1;
  logic       all1, busy1;
  logic [0:0] stage1;

  ready_seq_multi #(.NCH(4), .DLY(3)) dut (
    .clk(clk), .rstn(rstn), .restart_i(restart_i), .hold_i(hold_i),
    .ready_o(ready4), .all_ready_o(all4), .busy_o(busy4), .stage_o(stage4)
  );

  ready_seq_multi #(.NCH(1), .DLY(2)) dut_one (
    .clk(clk), .rstn(rstn), .restart_i(restart_i), .hold_i(hold_i),
    .ready_o(ready1), .all_ready_o(all1), .busy_o(busy1), .stage_o(stage1)
  );

  // clock
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int p4 = 0;
  int p1 = 0;
  logic [W-1:0] exp_q[$];

  // Reference: p counts effective sequencing cycles since reset/restart;
  // the number of raised channels is p/DLY, capped at NCH.
  function automatic logic [8:0] model4(int p);
    int c;
    c = p / 3;
    if (c > 4) c = 4;
    return {4'((1 << c) - 1), (c == 4), (c != 4), 3'(c)};
  endfunction

  function automatic logic [3:0] model1(int p);
    int c;
    c = p / 2;
    if (c > 1) c = 1;
    return {1'(c), (c == 1), (c != 1), 1'(c)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver + scoreboard: one clock edge per call
  task automatic step(logic r, logic rs, logic hd);
    logic [W-1:0] e;
    @(negedge clk);
    rstn = r; restart_i = rs; hold_i = hd;
    @(posedge clk);
    if (!r || rs) begin
      p4 = 0; p1 = 0;
    end else if (!hd) begin
      if (p4 < 100) p4++;
      if (p1 < 100) p1++;
    end
    exp_q.push_back({model4(p4), model1(p1)});
    #1;
    e = exp_q.pop_front();
    check("sb_nch4", {23'd0, ready4, all4, busy4, stage4}, {23'd0, e[12:4]});
    check("sb_nch1", {28'd0, ready1, all1, busy1, stage1}, {28'd0, e[3:0]});
  endtask

  task automatic reset_release();
    repeat (3) step(1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       restart;
    logic       hold;
    logic [3:0] ready;
    logic       all;
    logic [2:0] stage;
    logic       r1;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 4'b0001, 1'b0, 3'd1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 4'b0001, 1'b0, 3'd1, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 4'b0001, 1'b0, 3'd1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 4'b0011, 1'b0, 3'd2, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 4'b0011, 1'b0, 3'd2, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 4'b0011, 1'b0, 3'd2, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 4'b0111, 1'b0, 3'd3, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 4'b0111, 1'b0, 3'd3, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 4'b0111, 1'b0, 3'd3, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 4'b1111, 1'b1, 3'd4, 1'b1};

    // reset values, then plain release (NCH=4/DLY=3 and NCH=1/DLY=2)
    reset_release();
    check("rst_ready", {28'd0, ready4}, 32'd0);
    check("rst_busy", {31'd0, busy4}, 32'd1);
    check("rst_stage", {29'd0, stage4}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].restart, tbl[i].hold);
      check("tbl_ready", {28'd0, ready4}, {28'd0, tbl[i].ready});
      check("tbl_all", {31'd0, all4}, {31'd0, tbl[i].all});
      check("tbl_busy", {31'd0, busy4}, {31'd0, !tbl[i].all});
      check("tbl_stage", {29'd0, stage4}, {29'd0, tbl[i].stage});
      check("one_ready", {31'd0, ready1}, {31'd0, tbl[i].r1});
      check("one_all", {31'd0, all1}, {31'd0, tbl[i].r1});
      check("one_busy", {31'd0, busy1}, {31'd0, !tbl[i].r1});
    end

    // hold over edges 4..8 slips everything by five cycles
    reset_release();
    for (int e = 1; e <= 17; e++) begin
      step(1'b1, 1'b0, (e >= 4 && e <= 8));
      if (e == 3)  check("hold_e3", {28'd0, ready4}, 32'h1);
      if (e == 10) check("hold_e10", {28'd0, ready4}, 32'h1);
      if (e == 11) check("hold_e11", {28'd0, ready4}, 32'h3);
      if (e == 16) check("hold_e16_all", {31'd0, all4}, 32'd0);
      if (e == 17) check("hold_e17_all", {31'd0, all4}, 32'd1);
    end

    // restart pulse mid-sequence
    reset_release();
    for (int e = 1; e <= 10; e++) begin
      step(1'b1, (e == 7), 1'b0);
      if (e == 6)  check("rs_e6", {28'd0, ready4}, 32'h3);
      if (e == 7)  check("rs_e7_ready", {28'd0, ready4}, 32'h0);
      if (e == 7)  check("rs_e7_stage", {29'd0, stage4}, 32'h0);
      if (e == 9)  check("rs_e9", {28'd0, ready4}, 32'h0);
      if (e == 10) check("rs_e10", {28'd0, ready4}, 32'h1);
    end

    // restart on the edge ch3 would rise
    reset_release();
    for (int e = 1; e <= 14; e++) begin
      step(1'b1, (e == 12), 1'b0);
      check("rs_last_all", {31'd0, all4}, 32'd0);
      if (e == 12) check("rs_last_ready", {28'd0, ready4}, 32'h0);
      if (e == 12) check("rs_last_busy", {31'd0, busy4}, 32'd1);
    end

    // reset mid-sequence with restart and hold also high
    reset_release();
    for (int e = 1; e <= 4; e++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("mid_rst_ready", {28'd0, ready4}, 32'h0);
    check("mid_rst_all", {31'd0, all4}, 32'd0);
    check("mid_rst_busy", {31'd0, busy4}, 32'd1);
    check("mid_rst_stage", {29'd0, stage4}, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      step(1'b1, 1'b0, 1'b0);
      if (e == 2) check("mid_rst_e2", {28'd0, ready4}, 32'h0);
      if (e == 3) check("mid_rst_e3", {28'd0, ready4}, 32'h1);
    end

    // randomized run against the model
    reset_release();
    repeat (400) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
